// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: credit encodings (units of 5c),
// coin type select values and FSM state encodings, plus a saturating
// credit-subtract helper used when a coin is acknowledged.
package change_dispenser_pkg;

  // Credit encodings, identical to the vending controller's credit states.
  localparam logic [1:0] C0  = 2'b00;
  localparam logic [1:0] C5  = 2'b01;
  localparam logic [1:0] C10 = 2'b10;
  localparam logic [1:0] C15 = 2'b11;

  // Coin type on coin_sel.
  localparam logic NICKEL = 1'b0;
  localparam logic DIME   = 1'b1;

  // FSM state encodings.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEL   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  // Remaining credit after paying one coin; clamps at zero.
  function automatic logic [1:0] pay_coin(input logic [1:0] credit,
                                          input logic       coin);
    logic [1:0] value;
    value = (coin == DIME) ? 2'd2 : 2'd1;
    return (credit > value) ? (credit - value) : C0;
  endfunction

endpackage

// File: rtl/change_dispenser_gap_timer.sv
// gap_timer: loadable 4-bit down-counter with a zero flag. Times the hopper
// settle gap between consecutive coins.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   load  - load count with value (wins over dec)
//   value - value to load
//   dec   - decrement by one while nonzero
//   zero  - count is zero
module gap_timer
  import change_dispenser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a refund of 0..15c using nickels and dimes,
// one coin command at a time, with a settle gap between coins.
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset
//   req          - refund request, accepted only while ready
//   amount       - refund credit (00=0c, 01=5c, 10=10c, 11=15c)
//   nickel_empty - nickel tube empty (level)
//   dime_empty   - dime tube empty (level)
//   coin_ack     - hopper accepted the current coin command
//   ready        - idle, new request accepted
//   coin_vld     - coin command valid to hopper
//   coin_sel     - coin type (0=nickel, 1=dime), valid with coin_vld
//   done         - one-cycle pulse when refund fully paid
//   err          - sticky until reset: refund could not be completed
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] amount,
  input  logic       nickel_empty,
  input  logic       dime_empty,
  input  logic       coin_ack,
  output logic       ready,
  output logic       coin_vld,
  output logic       coin_sel,
  output logic       done,
  output logic       err
);

  logic [2:0] state;
  logic [1:0] remaining;
  logic       sel_q;
  logic       gap_load;
  logic       gap_dec;
  logic       gap_zero;

  // Loading GAP_CYCLES-1 and leaving GAP on the zero flag keeps the FSM
  // in GAP for exactly GAP_CYCLES cycles.
  assign gap_load = (state == S_ISSUE) && coin_ack;
  assign gap_dec  = (state == S_GAP);

  gap_timer u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (gap_load),
    .value (4'(GAP_CYCLES - 1)),
    .dec   (gap_dec),
    .zero  (gap_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= C0;
      sel_q     <= NICKEL;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            remaining <= amount;
            state     <= S_SEL;
          end
        end
        S_SEL: begin
          if (remaining == C0) begin
            state <= S_FIN;
          end else if ((remaining >= C10) && !dime_empty) begin
            sel_q <= DIME;
            state <= S_ISSUE;
          end else if (!nickel_empty) begin
            sel_q <= NICKEL;
            state <= S_ISSUE;
          end else begin
            state <= S_FAULT;
          end
        end
        S_ISSUE: begin
          if (coin_ack) begin
            remaining <= pay_coin(remaining, sel_q);
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_zero) begin
            state <= S_SEL;
          end
        end
        S_FIN:   state <= S_IDLE;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // All outputs are decodes of registered state.
  assign ready    = (state == S_IDLE);
  assign coin_vld = (state == S_ISSUE);
  assign coin_sel = sel_q;
  assign done     = (state == S_FIN);
  assign err      = (state == S_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table of refund vectors with
// expected coin sequences, plus directed multi-cycle corner cases.
module tb_change_dispenser;

  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] amount;
  logic       nickel_empty;
  logic       dime_empty;
  logic       coin_ack;
  logic       ready;
  logic       coin_vld;
  logic       coin_sel;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  change_dispenser #(.GAP_CYCLES(G)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .amount       (amount),
    .nickel_empty (nickel_empty),
    .dime_empty   (dime_empty),
    .coin_ack     (coin_ack),
    .ready        (ready),
    .coin_vld     (coin_vld),
    .coin_sel     (coin_sel),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] amt;
    logic       ne;
    logic       de;
    int         exp_coins;
    logic [2:0] exp_pattern;  // coins shifted in, first coin most significant
    int         exp_done;
    logic       exp_err;
    int         exp_rem;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; amount = 2'b00;
    nickel_empty = 1'b0; dime_empty = 1'b0; coin_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int coins, done_cnt, idle, gap_bad, extra_vld, err_drop;
    logic [2:0] pattern;
    logic finished;
    string tag;
    coins = 0; done_cnt = 0; idle = -1; gap_bad = 0;
    extra_vld = 0; err_drop = 0; pattern = '0; finished = 1'b0;
    tag = $sformatf("v%0d", idx);
    do_reset();
    nickel_empty = v.ne;
    dime_empty   = v.de;
    amount       = v.amt;
    req          = 1'b1;
    tick();
    req = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      if (done) begin
        if (idle >= 0 && idle != G + 1) gap_bad++;
        done_cnt++;
        finished = 1'b1;
      end else if (err) begin
        finished = 1'b1;
      end else if (coin_vld) begin
        if (!coin_ack) begin
          if (idle >= 0 && idle != G + 1) gap_bad++;
          pattern = {pattern[1:0], coin_sel};
          coins++;
          coin_ack = 1'b1;
        end
      end else begin
        if (coin_ack) begin
          coin_ack = 1'b0;
          idle = 1;
        end else if (idle >= 0) begin
          idle++;
        end
      end
      if (!finished) tick();
    end
    check({tag, "_finish"}, int'(finished), 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) done_cnt++;
      if (coin_vld) extra_vld++;
      if (err !== v.exp_err) err_drop++;
    end
    check({tag, "_coins"}, coins, v.exp_coins);
    check({tag, "_pattern"}, int'(pattern), int'(v.exp_pattern));
    check({tag, "_gap"}, gap_bad, 0);
    check({tag, "_done_cnt"}, done_cnt, v.exp_done);
    check({tag, "_err"}, int'(err), int'(v.exp_err));
    check({tag, "_err_hold"}, err_drop, 0);
    check({tag, "_vld_after"}, extra_vld, 0);
    check({tag, "_ready"}, int'(ready), int'(!v.exp_err));
    check({tag, "_remaining"}, int'(dut.remaining), v.exp_rem);
  endtask

  initial begin
    int vld_seen, seen;
    //          amt    ne    de  coins pattern done err rem
    vecs[0] = '{2'd3, 1'b0, 1'b0, 2, 3'b010, 1, 1'b0, 0};
    vecs[1] = '{2'd2, 1'b0, 1'b1, 2, 3'b000, 1, 1'b0, 0};
    vecs[2] = '{2'd1, 1'b1, 1'b0, 0, 3'b000, 0, 1'b1, 1};
    vecs[3] = '{2'd0, 1'b0, 1'b0, 0, 3'b000, 1, 1'b0, 0};
    vecs[4] = '{2'd2, 1'b0, 1'b0, 1, 3'b001, 1, 1'b0, 0};
    vecs[5] = '{2'd1, 1'b0, 1'b0, 1, 3'b000, 1, 1'b0, 0};
    vecs[6] = '{2'd3, 1'b1, 1'b0, 1, 3'b001, 0, 1'b1, 1};
    vecs[7] = '{2'd3, 1'b0, 1'b1, 3, 3'b000, 1, 1'b0, 0};
    vecs[8] = '{2'd2, 1'b1, 1'b1, 0, 3'b000, 0, 1'b1, 2};
    vecs[9] = '{2'd1, 1'b0, 1'b1, 1, 3'b000, 1, 1'b0, 0};

    // Reset state, with coin_ack ignored while idle.
    do_reset();
    check("rst_ready", int'(ready), 1);
    check("rst_vld", int'(coin_vld), 0);
    check("rst_sel", int'(coin_sel), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    coin_ack = 1'b1;
    tick();
    tick();
    check("idle_ack_vld", int'(coin_vld), 0);
    check("idle_ack_ready", int'(ready), 1);
    coin_ack = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // amount=0: done visible two cycles after the req cycle.
    do_reset();
    amount = 2'd0;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("z_sel_done", int'(done), 0);
    check("z_sel_ready", int'(ready), 0);
    tick();
    check("z_done", int'(done), 1);
    check("z_vld", int'(coin_vld), 0);
    tick();
    check("z_done_low", int'(done), 0);
    check("z_ready", int'(ready), 1);

    // Dime held in ISSUE for 20 cycles without ack; stray req ignored.
    do_reset();
    amount = 2'd2;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("st_vld_lat0", int'(coin_vld), 0);
    tick();
    check("st_vld_lat1", int'(coin_vld), 1);
    for (int i = 0; i < 20; i++) begin
      check("st_vld", int'(coin_vld), 1);
      check("st_sel", int'(coin_sel), 1);
      req = (i == 5);
      amount = (i == 5) ? 2'd1 : 2'd2;
      tick();
    end
    req = 1'b0;
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    check("st_vld_drop", int'(coin_vld), 0);
    vld_seen = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (coin_vld) vld_seen++;
      if (done) seen++;
      tick();
    end
    check("st_done", seen, 1);
    check("st_no_more_coins", vld_seen, 0);
    check("st_ready", int'(ready), 1);
    check("st_remaining", int'(dut.remaining), 0);

    // Reset in the same cycle as the ack of the first coin of 15c.
    do_reset();
    amount = 2'd3;
    req = 1'b1;
    tick();
    req = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !coin_vld; i++) tick();
    check("ra_vld_before", int'(coin_vld), 1);
    check("ra_sel_before", int'(coin_sel), 1);
    coin_ack = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    coin_ack = 1'b0;
    check("ra_ready", int'(ready), 1);
    check("ra_vld", int'(coin_vld), 0);
    check("ra_sel", int'(coin_sel), 0);
    check("ra_done", int'(done), 0);
    check("ra_err", int'(err), 0);
    check("ra_remaining", int'(dut.remaining), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (coin_vld || done) seen++;
    end
    check("ra_no_resume", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
